// File: rtl/wb_pwm_pkg.sv
// wb_pwm_pkg: register offsets, CTRL bit indices and counter type for wb_pwm.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pwm_pkg;

  // Byte offsets within the slave window; only address bits [5:2] are decoded.
  localparam logic [5:0] ADR_CTRL     = 6'h00;
  localparam logic [5:0] ADR_STATUS   = 6'h04;
  localparam logic [5:0] ADR_PERIOD   = 6'h08;
  localparam logic [5:0] ADR_PRESCALE = 6'h0C;
  localparam logic [5:0] ADR_DUTY0    = 6'h10;
  localparam logic [5:0] ADR_POLARITY = 6'h30;

  // CTRL register bit positions.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Default counter width and the matching counter type.
  localparam int DEF_CNT_WIDTH = 16;
  typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

  // Byte offset of duty register n.
  function automatic logic [5:0] duty_adr(input int n);
    return ADR_DUTY0 + 6'(4 * n);
  endfunction

endpackage

// File: rtl/wb_pwm_timebase.sv
// wb_pwm_timebase: shared prescaler and period counter for all PWM channels.
// Latency: tick/wrap are combinational from the current counter state; cnt is registered.
// Backpressure: none; both counters are held at 0 while i_en is low.
module wb_pwm_timebase #(
  parameter int CNT_WIDTH = 16,
  parameter int PRE_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic [PRE_WIDTH-1:0] i_prescale,
  input  logic [CNT_WIDTH-1:0] i_period,
  output logic                 o_tick,
  output logic                 o_wrap,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [PRE_WIDTH-1:0] r_pre_cnt;
  logic [CNT_WIDTH-1:0] r_cnt;

  assign o_tick = i_en & (r_pre_cnt == i_prescale);
  assign o_wrap = o_tick & (r_cnt == i_period);
  assign o_cnt  = r_cnt;

  // Prescaler counts 0..PRESCALE; the period counter steps on each tick and wraps after i_period.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_pre_cnt <= '0;
      r_cnt     <= '0;
    end else begin
      r_pre_cnt <= o_tick ? '0 : r_pre_cnt + PRE_WIDTH'(1);
      if (o_tick) begin
        r_cnt <= o_wrap ? '0 : r_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/wb_pwm.sv
// wb_pwm: Wishbone slave with CHANNELS edge-aligned PWM outputs, shadowed duty/period, wrap IRQ.
// Latency: ack/read data 1 cycle after strobe; pwm_o 1 cycle after the counter; intr 1 cycle after wrap.
// Backpressure: none; one access per 2 cycles. Optional output polarity via WB_PWM_POLARITY_EN.
module wb_pwm
  import wb_pwm_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PRE_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                intr,
  output logic [CHANNELS-1:0] pwm_o
);

  // Live registers.
  logic                 r_en;
  logic                 r_irq_en;
  logic                 r_wrap;
  logic [CNT_WIDTH-1:0] r_period;
  logic [PRE_WIDTH-1:0] r_prescale;
  logic [CNT_WIDTH-1:0] r_duty    [CHANNELS];
  // Shadows used by the running period.
  logic [CNT_WIDTH-1:0] r_period_sh;
  logic [CNT_WIDTH-1:0] r_duty_sh [CHANNELS];
  // Bus and output registers.
  logic                 r_ack;
  logic [31:0]          r_dat;
  logic                 r_intr;
  logic [CHANNELS-1:0]  r_pwm;

  logic                 w_acc;
  logic                 w_wr;
  logic [5:0]           w_off;
  logic [31:0]          w_rdata;
  logic                 w_clr;
  logic                 w_wrap_nxt;
  logic                 w_irq_nxt;
  logic                 w_tick;
  logic                 w_wrap;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic                 w_unused;

  // A new access is accepted only when no ack is outstanding, giving single-cycle acks.
  assign w_acc = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr  = w_acc & wb_we_i;
  assign w_off = {wb_adr_i[5:2], 2'b00};

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign intr     = r_intr;

  // Byte selects, undecoded address bits and the tick are intentionally not used.
  assign w_unused = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, w_tick};

  wb_pwm_timebase #(
    .CNT_WIDTH (CNT_WIDTH),
    .PRE_WIDTH (PRE_WIDTH)
  ) u_timebase (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_en       (r_en),
    .i_prescale (r_prescale),
    .i_period   (r_period_sh),
    .o_tick     (w_tick),
    .o_wrap     (w_wrap),
    .o_cnt      (w_cnt)
  );

`ifdef WB_PWM_POLARITY_EN
  logic [CHANNELS-1:0] r_pol;

  // Polarity register; inversion applies even while the generator is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pol <= '0;
    end else if (w_wr && (w_off == ADR_POLARITY)) begin
      r_pol <= wb_dat_i[CHANNELS-1:0];
    end
  end

  assign pwm_o = r_pwm ^ r_pol;
`else
  assign pwm_o = r_pwm;
`endif

  // Read mux: mapped registers zero-extended, everything else reads 0.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      ADR_CTRL: begin
        w_rdata[CTRL_EN]     = r_en;
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
      end
      ADR_STATUS:   w_rdata[0]             = r_wrap;
      ADR_PERIOD:   w_rdata[CNT_WIDTH-1:0] = r_period;
      ADR_PRESCALE: w_rdata[PRE_WIDTH-1:0] = r_prescale;
`ifdef WB_PWM_POLARITY_EN
      ADR_POLARITY: w_rdata[CHANNELS-1:0] = r_pol;
`endif
      default: ;
    endcase
    for (int n = 0; n < CHANNELS; n++) begin
      if (w_off == duty_adr(n)) begin
        w_rdata[CNT_WIDTH-1:0] = r_duty[n];
      end
    end
  end

  // Next WRAP and IRQ_EN: a wrap in the same cycle as a W1C keeps WRAP set.
  always_comb begin
    w_clr      = w_wr & (w_off == ADR_STATUS) & wb_dat_i[0];
    w_wrap_nxt = w_wrap | (r_wrap & ~w_clr);
    w_irq_nxt  = (w_wr && (w_off == ADR_CTRL)) ? wb_dat_i[CTRL_IRQ_EN] : r_irq_en;
  end

  // Bus handshake: ack and read data for one cycle, data 0 otherwise; reset drops an in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wb_we_i) ? w_rdata : '0;
    end
  end

  // Software-visible register writes, committed on the edge that raises ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_period   <= '0;
      r_prescale <= '0;
      for (int n = 0; n < CHANNELS; n++) r_duty[n] <= '0;
    end else if (w_wr) begin
      case (w_off)
        ADR_CTRL: begin
          r_en     <= wb_dat_i[CTRL_EN];
          r_irq_en <= wb_dat_i[CTRL_IRQ_EN];
        end
        ADR_PERIOD:   r_period   <= wb_dat_i[CNT_WIDTH-1:0];
        ADR_PRESCALE: r_prescale <= wb_dat_i[PRE_WIDTH-1:0];
        default: ;
      endcase
      for (int n = 0; n < CHANNELS; n++) begin
        if (w_off == duty_adr(n)) r_duty[n] <= wb_dat_i[CNT_WIDTH-1:0];
      end
    end
  end

  // WRAP flag and interrupt, both updated from the same next-state so intr tracks WRAP & IRQ_EN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap <= 1'b0;
      r_intr <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
      r_intr <= w_wrap_nxt & w_irq_nxt;
    end
  end

  // Shadows follow the live registers while disabled and otherwise reload only at a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period_sh <= '0;
      for (int n = 0; n < CHANNELS; n++) r_duty_sh[n] <= '0;
    end else if (!r_en || w_wrap) begin
      r_period_sh <= r_period;
      for (int n = 0; n < CHANNELS; n++) r_duty_sh[n] <= r_duty[n];
    end
  end

  // Per-channel compare, registered to keep the outputs glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_pwm[n] <= r_en & (w_cnt < r_duty_sh[n]);
      end
    end
  end

endmodule

// File: tb/tb_wb_pwm.sv
// tb_wb_pwm: randomized and directed checks of wb_pwm against a period-level reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_wb_pwm;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_stb_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic [3:0]    wb_sel_i = 4'hF;
  logic          wb_ack_o;
  logic          intr;
  logic [CH-1:0] pwm_o;

  wb_pwm #(.CHANNELS(CH), .CNT_WIDTH(CW), .PRE_WIDTH(PW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_ack_o (wb_ack_o),
    .intr     (intr),
    .pwm_o    (pwm_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ones [CH];

  // Reference model: live registers, period-level timeline and expected outputs.
  bit              m_en, m_irq, m_wrap, m_ack, m_intr;
  longint unsigned m_period, m_pre, m_pol;
  longint unsigned m_duty [CH];
  longint unsigned eff_period;
  longint unsigned eff_duty [CH];
  longint unsigned m_jp;          // cycles elapsed in the current PWM period
  logic [31:0]     m_rdat;
  logic [CH-1:0]   m_raw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] off);
    logic [31:0] v;
    v = '0;
    if (off == 6'h00) v = {30'b0, m_irq, m_en};
    else if (off == 6'h04) v = {31'b0, m_wrap};
    else if (off == 6'h08) v = 32'(m_period);
    else if (off == 6'h0C) v = 32'(m_pre);
`ifdef WB_PWM_POLARITY_EN
    else if (off == 6'h30) v = 32'(m_pol);
`endif
    else if (off >= 6'h10 && off < 6'(16 + 4 * CH)) v = 32'(m_duty[(off - 6'h10) >> 2]);
    return v;
  endfunction

  function automatic void model_write(input logic [5:0] off, input logic [31:0] d);
    if (off == 6'h00) begin m_en = d[0]; m_irq = d[1]; end
    else if (off == 6'h08) m_period = d & ((32'd1 << CW) - 1);
    else if (off == 6'h0C) m_pre = d & ((32'd1 << PW) - 1);
`ifdef WB_PWM_POLARITY_EN
    else if (off == 6'h30) m_pol = d & ((32'd1 << CH) - 1);
`endif
    else if (off >= 6'h10 && off < 6'(16 + 4 * CH)) m_duty[(off - 6'h10) >> 2] = d & ((32'd1 << CW) - 1);
  endfunction

  // Advance one clock, update the model for that edge, then compare every output.
  task automatic step();
    bit              acc, wrap_c, clr;
    longint unsigned len, cnt_c;
    logic [CH-1:0]   raw;
    logic [31:0]     rd;
    logic [5:0]      off;
    off    = {wb_adr_i[5:2], 2'b00};
    acc    = wb_stb_i && wb_cyc_i && !m_ack;
    len    = (eff_period + 1) * (m_pre + 1);
    cnt_c  = m_jp / (m_pre + 1);
    wrap_c = m_en && (m_jp == len - 1);
    for (int n = 0; n < CH; n++) raw[n] = m_en && (cnt_c < eff_duty[n]);
    rd = (acc && !wb_we_i) ? model_read(off) : '0;
    @(posedge clk);
    if (reset) begin
      m_en = 0; m_irq = 0; m_wrap = 0; m_ack = 0; m_intr = 0;
      m_period = 0; m_pre = 0; m_pol = 0; eff_period = 0; m_jp = 0;
      m_rdat = '0; m_raw = '0;
      for (int n = 0; n < CH; n++) begin m_duty[n] = 0; eff_duty[n] = 0; end
    end else begin
      clr    = acc && wb_we_i && (off == 6'h04) && wb_dat_i[0];
      m_wrap = wrap_c || (m_wrap && !clr);
      if (!m_en || wrap_c) begin
        eff_period = m_period;
        eff_duty   = m_duty;
      end
      m_jp = (!m_en || wrap_c) ? 0 : m_jp + 1;
      if (acc && wb_we_i) model_write(off, wb_dat_i);
      m_ack  = acc;
      m_rdat = rd;
      m_raw  = raw;
      m_intr = m_wrap && m_irq;
    end
    #1;
    check("ack",  32'(wb_ack_o), 32'(m_ack));
    check("rdat", wb_dat_o, m_rdat);
    check("intr", 32'(intr), 32'(m_intr));
    check("pwm",  32'(pwm_o), 32'(m_raw ^ CH'(m_pol)));
    for (int n = 0; n < CH; n++) ones[n] += int'(pwm_o[n]);
  endtask

  task automatic bus_wr(input logic [5:0] off, input logic [31:0] d);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = {26'h0, off}; wb_dat_i = d;
    step();
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    step();
  endtask

  task automatic bus_rd(input logic [5:0] off, output logic [31:0] d);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = {26'h0, off};
    step();
    d = wb_dat_o;
    wb_cyc_i = 0; wb_stb_i = 0;
    step();
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic clear_ones();
    for (int n = 0; n < CH; n++) ones[n] = 0;
  endtask

  // Step until the current cycle is the first of a PWM period (bounded).
  task automatic align();
    int k;
    k = 0;
    while (m_jp != 0 && k < 500) begin step(); k++; end
    check("align_timeout", 32'(m_jp == 0), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int          k;
    bit          seen;

    // Reset values and ack timing on every register.
    do_reset();
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_pwm",  32'(pwm_o), 32'd0);
    for (int a = 0; a <= 12; a++) begin
      bus_rd(6'(4 * a), d);
      check("rst_reg", d, 32'd0);
    end

    // Basic PWM: period 10 clk, 3 high.
    bus_wr(6'h08, 32'd9);
    bus_wr(6'h10, 32'd3);
    bus_wr(6'h00, 32'd1);
    align();
    clear_ones();
    repeat (30) step();
    check("basic_high", 32'(ones[0]), 32'd9);

    // Glitch-free update mid-period: current period keeps 3, next gets 7.
    align();
    clear_ones();
    repeat (5) step();
    bus_wr(6'h10, 32'd7);
    repeat (3) step();
    check("glitch_old", 32'(ones[0]), 32'd3);
    clear_ones();
    repeat (10) step();
    check("glitch_new", 32'(ones[0]), 32'd7);

    // Interrupt rise, W1C clear, and W1C colliding with a wrap.
    bus_wr(6'h00, 32'd3);
    seen = 0;
    k = 0;
    while (!seen && k < 40) begin step(); seen = intr; k++; end
    check("irq_rise", 32'(seen), 32'd1);
    bus_wr(6'h04, 32'd1);
    check("irq_clr", 32'(intr), 32'd0);
    k = 0;
    while (m_jp != 9 && k < 40) begin step(); k++; end
    bus_wr(6'h04, 32'd1);
    check("w1c_on_wrap", 32'(intr), 32'd1);
    bus_rd(6'h04, d);
    check("w1c_status", d, 32'd1);

    // Duty extremes with prescale 2: period 30 clk.
    do_reset();
    bus_wr(6'h08, 32'd9);
    bus_wr(6'h10, 32'd3);
    bus_wr(6'h14, 32'd0);
    bus_wr(6'h18, 32'd12);
    bus_wr(6'h0C, 32'd2);
    bus_wr(6'h00, 32'd1);
    align();
    clear_ones();
    repeat (60) step();
    check("pre_duty3",  32'(ones[0]), 32'd18);
    check("duty_zero",  32'(ones[1]), 32'd0);
    check("duty_over",  32'(ones[2]), 32'd60);

    // Optional polarity feature.
    do_reset();
`ifdef WB_PWM_POLARITY_EN
    bus_wr(6'h30, 32'd1);
    check("pol_idle", 32'(pwm_o[0]), 32'd1);
    bus_wr(6'h08, 32'd9);
    bus_wr(6'h10, 32'd3);
    bus_wr(6'h00, 32'd1);
    align();
    clear_ones();
    repeat (10) step();
    check("pol_high", 32'(ones[0]), 32'd7);
`else
    bus_wr(6'h30, 32'hFFFF_FFFF);
    bus_rd(6'h30, d);
    check("pol_absent", d, 32'd0);
`endif

    // Randomized configurations with mid-run traffic; upper data bits exercise truncation.
    for (int it = 0; it < 8; it++) begin
      bus_wr(6'h00, 32'd0);
      bus_wr(6'h08, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 12));
      bus_wr(6'h0C, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3));
      for (int n = 0; n < CH; n++)
        bus_wr(6'(16 + 4 * n), ($urandom & 32'hFFFF_0000) | $urandom_range(0, 15));
      bus_wr(6'h00, {30'b0, 1'($urandom_range(0, 1)), 1'b1});
      repeat ($urandom_range(40, 120)) begin
        case ($urandom_range(0, 9))
          0: bus_wr(6'(16 + 4 * $urandom_range(0, CH - 1)), 32'($urandom_range(0, 15)));
          1: bus_wr(6'h08, 32'($urandom_range(0, 12)));
          2: bus_wr(6'h04, 32'd1);
          3: bus_rd(6'(4 * $urandom_range(0, 15)), d);
          4: begin wb_cyc_i = 1; step(); wb_cyc_i = 0; end
          default: step();
        endcase
      end
    end

    // Reset arriving with a write in flight: no ack, registers stay at reset values.
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h0; wb_dat_i = 32'd3;
    reset = 1;
    step();
    check("rst_inflight_ack", 32'(wb_ack_o), 32'd0);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    step();
    reset = 0;
    bus_rd(6'h00, d);
    check("rst_inflight_ctrl", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
